c4_win_detector: RTL and testbench

//  Downstream of the Connect Four board register. Consumes the 42-bit red and blue

---
 rtl/connect4_pkg.sv | 28 ++
 rtl/c4_line_index.sv | 41 ++++
 rtl/c4_win_detector.sv | 150 +++++++++++++++
 tb/tb_c4_win_detector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared Connect Four board geometry, scan enums and the cell index helper.
// Bit index of a cell is row*COLS + col with row 0 at the bottom.
package connect4_pkg;

  localparam int ROWS    = 6;
  localparam int COLS    = 7;
  localparam int CELLS   = ROWS * COLS;
  localparam int WIN_LEN = 4;
  localparam int IDX_W   = 6;

  typedef enum logic [1:0] {
    DIR_H  = 2'd0,
    DIR_V  = 2'd1,
    DIR_UR = 2'd2,
    DIR_UL = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic [IDX_W-1:0] cell_idx(input int row, input int col);
    return IDX_W'(row * COLS + col);
  endfunction

endpackage

// File: rtl/c4_line_index.sv
// Maps a (row, col, direction) scan pair to its WIN_LEN cell indices and
// flags whether the whole line lies on the board (no wrap across rows).
module c4_line_index
  import connect4_pkg::*;
(
  input  logic [2:0]                      row_i,
  input  logic [2:0]                      col_i,
  input  dir_e                            dir_i,
  output logic                            valid_o,
  output logic [WIN_LEN-1:0][IDX_W-1:0]   idx_o
);

  int dr;
  int dc;
  int end_r;
  int end_c;

  // NOTE: every signal driven here gets a default before the case so no latch is inferred.
  always_comb begin
    dr = 0;
    dc = 0;
    case (dir_i)
      DIR_H:  dc = 1;
      DIR_V:  dr = 1;
      DIR_UR: begin dr = 1; dc = 1;  end
      DIR_UL: begin dr = 1; dc = -1; end
      default: ;
    endcase

    end_r   = int'(row_i) + (WIN_LEN - 1) * dr;
    end_c   = int'(col_i) + (WIN_LEN - 1) * dc;
    valid_o = (int'(row_i) < ROWS) && (int'(col_i) < COLS) &&
              (end_r < ROWS) && (end_c >= 0) && (end_c < COLS);

    for (int k = 0; k < WIN_LEN; k++) begin
      idx_o[k] = valid_o ? cell_idx(int'(row_i) + k * dr, int'(col_i) + k * dc)
                         : '0;
    end
  end

endmodule

// File: rtl/c4_win_detector.sv
// Connect Four win/draw detector: snapshots both boards on start, scans one
// (cell, direction) pair per cycle. Optional win mask via C4_WIN_MASK_EN.
module c4_win_detector
  import connect4_pkg::*;
(
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [CELLS-1:0] red,
  input  logic [CELLS-1:0] blue,
  input  logic [5:0]       boardcount,
  output logic             busy,
  output logic             done,
  output logic             red_win,
  output logic             blue_win,
  output logic             draw,
  output logic [CELLS-1:0] win_mask
);

  localparam logic [2:0] LAST_ROW   = 3'(ROWS - 1);
  localparam logic [2:0] LAST_COL   = 3'(COLS - 1);
  localparam logic [5:0] FULL_COUNT = 6'(CELLS);

  state_e                        state_q, state_d;
  logic [2:0]                    row_q, col_q;
  logic [1:0]                    dir_q;
  logic [CELLS-1:0]              red_snap_q, blue_snap_q;
  logic [5:0]                    count_snap_q;
  logic                          red_found_q, blue_found_q;
  logic                          done_q, red_win_q, blue_win_q, draw_q;

  logic                          line_valid;
  logic [WIN_LEN-1:0][IDX_W-1:0] line_idx;
  logic                          last_pair, red_hit, blue_hit;

  c4_line_index u_line_index (
    .row_i   (row_q),
    .col_i   (col_q),
    .dir_i   (dir_e'(dir_q)),
    .valid_o (line_valid),
    .idx_o   (line_idx)
  );

  assign red_hit  = line_valid &
                    red_snap_q[line_idx[0]]  & red_snap_q[line_idx[1]] &
                    red_snap_q[line_idx[2]]  & red_snap_q[line_idx[3]];
  assign blue_hit = line_valid &
                    blue_snap_q[line_idx[0]] & blue_snap_q[line_idx[1]] &
                    blue_snap_q[line_idx[2]] & blue_snap_q[line_idx[3]];

  assign last_pair = (row_q == LAST_ROW) && (col_q == LAST_COL) && (dir_q == 2'd3);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_SCAN;
      S_SCAN:  if (last_pair) state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the snapshot boards are plain registers, not a memory, so they take reset like the rest.
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      dir_q        <= '0;
      red_snap_q   <= '0;
      blue_snap_q  <= '0;
      count_snap_q <= '0;
      red_found_q  <= 1'b0;
      blue_found_q <= 1'b0;
      done_q       <= 1'b0;
      red_win_q    <= 1'b0;
      blue_win_q   <= 1'b0;
      draw_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: if (start) begin
          red_snap_q   <= red;
          blue_snap_q  <= blue;
          count_snap_q <= boardcount;
          row_q        <= '0;
          col_q        <= '0;
          dir_q        <= '0;
          red_found_q  <= 1'b0;
          blue_found_q <= 1'b0;
        end
        S_SCAN: begin
          // Direction runs fastest, then column, then row.
          dir_q <= dir_q + 2'd1;
          if (dir_q == 2'd3) begin
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= row_q + 3'd1;
            end else begin
              col_q <= col_q + 3'd1;
            end
          end
          if (red_hit)  red_found_q  <= 1'b1;
          if (blue_hit) blue_found_q <= 1'b1;
        end
        S_DONE: begin
          done_q     <= 1'b1;
          red_win_q  <= red_found_q;
          blue_win_q <= blue_found_q;
          draw_q     <= (count_snap_q == FULL_COUNT) && !red_found_q && !blue_found_q;
        end
        default: ;
      endcase
    end
  end

`ifdef C4_WIN_MASK_EN
  logic [CELLS-1:0] line_mask;
  logic [CELLS-1:0] mask_q;

  always_comb begin
    line_mask = '0;
    for (int k = 0; k < WIN_LEN; k++) line_mask[line_idx[k]] = 1'b1;
  end

  // The first run found in scan order is kept; red wins ties at the same pair.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mask_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      mask_q <= '0;
    end else if (state_q == S_SCAN && mask_q == '0 && (red_hit || blue_hit)) begin
      mask_q <= line_mask;
    end
  end

  assign win_mask = mask_q;
`else
  assign win_mask = '0;
`endif

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign red_win  = red_win_q;
  assign blue_win = blue_win_q;
  assign draw     = draw_q;

endmodule

// File: tb/tb_c4_win_detector.sv
// Directed table-driven bench for c4_win_detector, plus hand-written sequences
// for start-while-busy and reset-mid-scan. Mask checks follow C4_WIN_MASK_EN.
module tb_c4_win_detector;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [41:0] red, blue;
  logic [5:0]  boardcount;
  logic        busy, done, red_win, blue_win, draw;
  logic [41:0] win_mask;

  int errors = 0;
  int checks = 0;
  logic prev_red = 1'b0, prev_blue = 1'b0, prev_draw = 1'b0;

  always #5 clk = ~clk;

  c4_win_detector dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .red        (red),
    .blue       (blue),
    .boardcount (boardcount),
    .busy       (busy),
    .done       (done),
    .red_win    (red_win),
    .blue_win   (blue_win),
    .draw       (draw),
    .win_mask   (win_mask)
  );

  typedef struct {
    string       name;
    logic [41:0] red;
    logic [41:0] blue;
    logic [5:0]  cnt;
    logic        exp_red;
    logic        exp_blue;
    logic        exp_draw;
    logic [41:0] exp_mask;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] bits4(input int a, input int b, input int c, input int d);
    logic [41:0] m;
    m = '0;
    m[a] = 1'b1; m[b] = 1'b1; m[c] = 1'b1; m[d] = 1'b1;
    return m;
  endfunction

  function automatic logic [41:0] mask_exp(input logic [41:0] m);
`ifdef C4_WIN_MASK_EN
    return m;
`else
    if (m != '0) return '0;
    return '0;
`endif
  endfunction

  // Two-row stripes with alternating columns: no line of four anywhere.
  function automatic logic [41:0] stripe_board(input bit colour);
    logic [41:0] m;
    m = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if (((c + (r >> 1)) % 2) == int'(colour)) m[r*7 + c] = 1'b1;
    return m;
  endfunction

  task automatic launch(input logic [41:0] r, input logic [41:0] b, input logic [5:0] cnt);
    @(negedge clk);
    red = r; blue = b; boardcount = cnt; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic check_results(input string name, input logic er, input logic eb,
                               input logic ed, input logic [41:0] em);
    check({name, " red_win"},  64'(red_win),  64'(er));
    check({name, " blue_win"}, 64'(blue_win), 64'(eb));
    check({name, " draw"},     64'(draw),     64'(ed));
    check({name, " win_mask"}, 64'(win_mask), 64'(mask_exp(em)));
    check({name, " busy_at_done"}, 64'(busy), 64'(0));
    prev_red = er; prev_blue = eb; prev_draw = ed;
  endtask

  task automatic run_vec(input vec_t v);
    int  n;
    bit  seen;
    launch(v.red, v.blue, v.cnt);
    check({v.name, " busy_after_start"}, 64'(busy), 64'(1));
    seen = 1'b0;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (n == 50) begin
        check({v.name, " hold_red"},  64'(red_win),  64'(prev_red));
        check({v.name, " hold_blue"}, 64'(blue_win), 64'(prev_blue));
        check({v.name, " hold_draw"}, 64'(draw),     64'(prev_draw));
      end
      if (n == 168) check({v.name, " busy_in_done_state"}, 64'(busy), 64'(1));
      if (done) begin seen = 1'b1; break; end
    end
    check({v.name, " done_latency"}, 64'(seen ? n : 999), 64'(169));
    check_results(v.name, v.exp_red, v.exp_blue, v.exp_draw, v.exp_mask);
    @(posedge clk); #1;
    check({v.name, " done_one_cycle"}, 64'(done), 64'(0));
  endtask

  initial begin
    int  n;
    bit  seen;
    int  pulses;

    vecs[0] = '{"h_row0",   bits4(0,1,2,3),     '0,                  6'd4,  1, 0, 0, 42'hF};
    vecs[1] = '{"v_colG",   '0,                 bits4(6,13,20,27),   6'd4,  0, 1, 0, bits4(6,13,20,27)};
    vecs[2] = '{"wrap",     bits4(4,5,6,7),     '0,                  6'd4,  0, 0, 0, '0};
    vecs[3] = '{"diag_ul",  bits4(3,9,15,21),   '0,                  6'd4,  1, 0, 0, bits4(3,9,15,21)};
    vecs[4] = '{"full_draw", stripe_board(1'b0), stripe_board(1'b1), 6'd42, 0, 0, 1, '0};
    vecs[5] = '{"both_win", bits4(0,1,2,3),     bits4(7,8,9,10),     6'd8,  1, 1, 0, 42'hF};
    vecs[6] = '{"blue_first", bits4(35,36,37,38), bits4(0,1,2,3),    6'd8,  1, 1, 0, 42'hF};
    vecs[7] = '{"diag_ur_full", bits4(10,18,26,34), '0,              6'd42, 1, 0, 0, bits4(10,18,26,34)};

    resetn = 1'b0; start = 1'b0; red = '0; blue = '0; boardcount = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy",     64'(busy),     64'(0));
    check("reset done",     64'(done),     64'(0));
    check("reset red_win",  64'(red_win),  64'(0));
    check("reset blue_win", 64'(blue_win), 64'(0));
    check("reset draw",     64'(draw),     64'(0));
    check("reset win_mask", 64'(win_mask), 64'(0));
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Start re-pulsed mid-scan with different inputs must be ignored.
    launch(bits4(0,1,2,3), '0, 6'd4);
    seen = 1'b0;
    for (n = 1; n <= 200; n++) begin
      if (n == 50) begin
        start = 1'b1; red = '0; blue = bits4(6,13,20,27); boardcount = 6'd42;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin seen = 1'b1; break; end
    end
    check("restart done_latency", 64'(seen ? n : 999), 64'(169));
    check_results("restart", 1'b1, 1'b0, 1'b0, 42'hF);

    // Reset sampled at T+100 aborts the scan and clears all outputs.
    launch('0, bits4(6,13,20,27), 6'd4);
    for (n = 1; n < 100; n++) begin @(posedge clk); #1; end
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midreset busy",     64'(busy),     64'(0));
    check("midreset done",     64'(done),     64'(0));
    check("midreset red_win",  64'(red_win),  64'(0));
    check("midreset blue_win", 64'(blue_win), 64'(0));
    check("midreset win_mask", 64'(win_mask), 64'(0));
    resetn = 1'b1;
    prev_red = 1'b0; prev_blue = 1'b0; prev_draw = 1'b0;
    pulses = 0;
    for (n = 0; n < 120; n++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    check("midreset no_done", 64'(pulses), 64'(0));

    run_vec(vecs[3]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
